// File: rtl/i2c_codec_target_if.sv
// Register-write/readback bundle of the I2C codec target.
// The master side produces write events and read data; the slave side consumes them.
interface i2c_codec_target_if;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, busy, rd_data,
    input  rd_addr
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, busy, rd_data,
    output rd_addr
  );
endinterface

// File: rtl/i2c_codec_target.sv
// Write-only I2C target for a codec: takes 2-byte register writes (7-bit addr, 9-bit data)
// into a 10-entry register file; address 15 clears the file.
module i2c_codec_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk_50mhz,
  input  logic       rst_i,
  input  logic       i2c_sclk_i,
  inout  wire        i2c_sdin_io,
  output logic       wr_valid_o,
  output logic [6:0] wr_addr_o,
  output logic [8:0] wr_data_o,
  output logic       busy_o,
  input  logic [3:0] rd_addr_i,
  output logic [8:0] rd_data_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
  } state_t;

  logic [1:0]          scl_s_q, sda_s_q;
  logic [FILT_LEN-1:0] scl_h_q, sda_h_q;
  logic                scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] sr_q, byte1_q;
  logic       sda_oe_q, busy_q, wr_pend_q, wr_valid_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q;
  logic [8:0] regs_q [10];

  logic scl_rise, scl_fall, start_det, stop_det;

  assign i2c_sdin_io = sda_oe_q ? 1'b0 : 1'bz;

  // Two-flop synchronizers followed by an N-sample agreement filter per line.
  always_ff @(posedge clk_50mhz or posedge rst_i) begin
    if (rst_i) begin
      scl_s_q <= '1;
      sda_s_q <= '1;
      scl_h_q <= '1;
      sda_h_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_s_q <= {scl_s_q[0], i2c_sclk_i};
      sda_s_q <= {sda_s_q[0], i2c_sdin_io};
      scl_h_q <= {scl_h_q[FILT_LEN-2:0], scl_s_q[1]};
      sda_h_q <= {sda_h_q[FILT_LEN-2:0], sda_s_q[1]};
      if (&scl_h_q)       scl_f_q <= 1'b1;
      else if (~|scl_h_q) scl_f_q <= 1'b0;
      if (&sda_h_q)       sda_f_q <= 1'b1;
      else if (~|sda_h_q) sda_f_q <= 1'b0;
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  always_ff @(posedge clk_50mhz or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      byte1_q    <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_pend_q;
      wr_pend_q  <= 1'b0;
      if (stop_det) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (scl_rise) begin
        if ((state_q inside {ADDR, BYTE1, BYTE2}) && bit_cnt_q != 4'd8) begin
          sr_q      <= {sr_q[6:0], sda_f_q};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (scl_fall) begin
        // Each ACK state is entered on the fall after bit 8 and left on the fall after bit 9.
        case (state_q)
          ADDR: if (bit_cnt_q == 4'd8) begin
            bit_cnt_q <= '0;
            if (sr_q == {DEV_ADDR, 1'b0}) begin
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q  <= IGNORE;
              busy_q   <= 1'b0;
            end
          end
          ADDR_ACK: begin
            sda_oe_q <= 1'b0;
            state_q  <= BYTE1;
          end
          BYTE1: if (bit_cnt_q == 4'd8) begin
            bit_cnt_q <= '0;
            byte1_q   <= sr_q;
            sda_oe_q  <= 1'b1;
            state_q   <= ACK1;
          end
          ACK1: begin
            sda_oe_q <= 1'b0;
            state_q  <= BYTE2;
          end
          BYTE2: if (bit_cnt_q == 4'd8) begin
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b1;
            state_q   <= ACK2;
          end
          ACK2: begin
            sda_oe_q  <= 1'b0;
            state_q   <= IGNORE;
            wr_addr_q <= byte1_q[7:1];
            wr_data_q <= {byte1_q[0], sr_q};
            wr_pend_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 10; i++) regs_q[i] <= '0;
    end else if (wr_valid_q) begin
      if (wr_addr_q == 7'd15) begin
        for (int unsigned i = 0; i < 10; i++) regs_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < 10; i++)
          if (wr_addr_q == 7'(i)) regs_q[i] <= wr_data_q;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < 10; i++)
      if (rd_addr_i == 4'(i)) rd_data_o = regs_q[i];
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bus-level bench for i2c_codec_target: a bit-banged I2C master, a write monitor and a
// rule-based model of acks, writes and register contents.
module tb_i2c_codec_target;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_bus;

  always #10 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_codec_target_if bus_if ();

  i2c_codec_target #(.DEV_ADDR(7'h1A), .FILT_LEN(3)) dut (
    .clk_50mhz  (clk),
    .rst_i      (rst),
    .i2c_sclk_i (m_scl),
    .i2c_sdin_io(sda_bus),
    .wr_valid_o (bus_if.wr_valid),
    .wr_addr_o  (bus_if.wr_addr),
    .wr_data_o  (bus_if.wr_data),
    .busy_o     (bus_if.busy),
    .rd_addr_i  (bus_if.rd_addr),
    .rd_data_o  (bus_if.rd_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor and unexpected-SDA-drive counter
  int         n_wr = 0;
  int         wide_pulse = 0;
  int         dut_low_cnt = 0;
  logic       prev_wv = 1'b0;
  logic [6:0] last_a = '0;
  logic [8:0] last_d = '0;

  always @(negedge clk) begin
    if (bus_if.wr_valid === 1'b1) begin
      n_wr++;
      last_a = bus_if.wr_addr;
      last_d = bus_if.wr_data;
      if (prev_wv) wide_pulse++;
    end
    prev_wv = (bus_if.wr_valid === 1'b1);
    if (sda_bus === 1'b0 && !m_sda_low) dut_low_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // I2C master; lines change 2 ns after a rising clk edge
  task automatic wq();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wq();
    m_scl = 1'b1;     wq();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b0;     wq();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b1;     wq();
    m_sda_low = 1'b0; wq();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda_low = ~b;
    wq();
    if (glitch) begin
      m_scl = 1'b1;
      @(posedge clk); #2;
      m_scl = 1'b0;
      wq();
    end
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    m_sda_low = 1'b0; wq();
    m_scl = 1'b1;     wq();
    ack = (sda_bus === 1'b0);
    wq();
    m_scl = 1'b0;     wq();
  endtask

  task automatic xfer(input logic [3:0][7:0] b, input int n, input int glitch_bit,
                      output logic [3:0] ackm, output logic busy_mid);
    logic a;
    ackm = '0;
    busy_mid = 1'b0;
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], (i == 1) ? glitch_bit : -1, a);
      ackm[i] = a;
      if (i == 0) busy_mid = bus_if.busy;
    end
    i2c_stop();
    repeat (5) @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0][7:0] mk(input logic [7:0] b0, b1, b2, b3);
    logic [3:0][7:0] r;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
    return r;
  endfunction

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    int              glitch;
    logic [3:0]      ack;
    logic            wr;
    logic [6:0]      a;
    logic [8:0]      d;
    logic [3:0]      ridx;
    logic [8:0]      rexp;
  } vec_t;

  vec_t vt [9];

  // Reference model: target 0x1A write address is 0x34; bytes 0..2 acked if addressed.
  logic [8:0] ref_regs [10];

  function automatic logic [8:0] ref_read(input logic [3:0] idx);
    return (idx <= 4'd9) ? ref_regs[idx] : 9'd0;
  endfunction

  initial begin
    logic [3:0] ackm;
    logic       busy_mid;
    int         n0;
    bit         seen;

    vt[0] = '{mk(8'h34, 8'h0C, 8'h1F, 8'h00), 3, -1, 4'b0111, 1'b1, 7'd6,  9'h01F, 4'd6, 9'h01F};
    vt[1] = '{mk(8'h34, 8'h0C, 8'h00, 8'h00), 2, -1, 4'b0011, 1'b0, 7'd0,  9'h000, 4'd6, 9'h01F};
    vt[2] = '{mk(8'h34, 8'h0D, 8'h55, 8'hAA), 4, -1, 4'b0111, 1'b1, 7'd6,  9'h155, 4'd6, 9'h155};
    vt[3] = '{mk(8'h36, 8'h0C, 8'h1F, 8'h00), 3, -1, 4'b0000, 1'b0, 7'd0,  9'h000, 4'd6, 9'h155};
    vt[4] = '{mk(8'h35, 8'h0C, 8'h00, 8'h00), 2, -1, 4'b0000, 1'b0, 7'd0,  9'h000, 4'd6, 9'h155};
    vt[5] = '{mk(8'h34, 8'h14, 8'h55, 8'h00), 3, -1, 4'b0111, 1'b1, 7'd10, 9'h055, 4'd6, 9'h155};
    vt[6] = '{mk(8'h34, 8'h13, 8'hAB, 8'h00), 3, -1, 4'b0111, 1'b1, 7'd9,  9'h1AB, 4'd9, 9'h1AB};
    vt[7] = '{mk(8'h34, 8'h0D, 8'hFF, 8'h00), 3,  4, 4'b0111, 1'b1, 7'd6,  9'h1FF, 4'd6, 9'h1FF};
    vt[8] = '{mk(8'h34, 8'h1E, 8'h00, 8'h00), 3, -1, 4'b0111, 1'b1, 7'd15, 9'h000, 4'd9, 9'h000};

    bus_if.rd_addr = 4'd6;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_wr_valid", 32'(bus_if.wr_valid), 32'd0);
    chk("rst_wr_addr",  32'(bus_if.wr_addr),  32'd0);
    chk("rst_wr_data",  32'(bus_if.wr_data),  32'd0);
    chk("rst_busy",     32'(bus_if.busy),     32'd0);
    chk("rst_sda",      32'(sda_bus),         32'd1);
    chk("rst_rd_data",  32'(bus_if.rd_data),  32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    for (int k = 0; k < 9; k++) begin
      n0 = n_wr;
      dut_low_cnt = 0;
      xfer(vt[k].b, vt[k].n, vt[k].glitch, ackm, busy_mid);
      chk($sformatf("vec%0d_ack", k), 32'(ackm), 32'(vt[k].ack));
      chk($sformatf("vec%0d_busy_mid", k), 32'(busy_mid), 32'(vt[k].ack[0]));
      chk($sformatf("vec%0d_busy_end", k), 32'(bus_if.busy), 32'd0);
      chk($sformatf("vec%0d_nwr", k), 32'(n_wr - n0), 32'(vt[k].wr));
      if (vt[k].wr) begin
        chk($sformatf("vec%0d_wr_addr", k), 32'(last_a), 32'(vt[k].a));
        chk($sformatf("vec%0d_wr_data", k), 32'(last_d), 32'(vt[k].d));
      end
      if (!vt[k].ack[0]) chk($sformatf("vec%0d_sda_idle", k), 32'(dut_low_cnt), 32'd0);
      bus_if.rd_addr = vt[k].ridx;
      #1;
      chk($sformatf("vec%0d_rd", k), 32'(bus_if.rd_data), 32'(vt[k].rexp));
    end

    for (int r = 0; r < 16; r++) begin
      bus_if.rd_addr = 4'(r);
      #1;
      chk($sformatf("cleared_rd%0d", r), 32'(bus_if.rd_data), 32'd0);
    end

    // Randomized transactions against the rule model (file is all-zero after the clear above)
    for (int i = 0; i < 10; i++) ref_regs[i] = '0;
    for (int t = 0; t < 14; t++) begin
      logic [3:0][7:0] b;
      logic [3:0]      eack;
      logic            addressed, ewr;
      logic [6:0]      ea;
      logic [8:0]      ed;
      logic [3:0]      ridx;
      int              n, sel, ra;
      sel = $urandom_range(0, 3);
      b[0] = (sel < 2) ? 8'h34 : (sel == 2) ? 8'h35 : 8'($urandom);
      ra = $urandom_range(0, 16);
      b[1] = {7'(ra), 1'($urandom)};
      b[2] = 8'($urandom);
      b[3] = 8'($urandom);
      n = $urandom_range(1, 4);
      addressed = (b[0] == 8'h34);
      eack = '0;
      for (int i = 0; i < n && i < 3; i++) eack[i] = addressed;
      ewr = addressed && (n >= 3);
      ea = b[1][7:1];
      ed = {b[1][0], b[2]};
      if (ewr) begin
        if (ea == 7'd15) for (int i = 0; i < 10; i++) ref_regs[i] = '0;
        else if (ea <= 7'd9) ref_regs[ea] = ed;
      end
      n0 = n_wr;
      dut_low_cnt = 0;
      xfer(b, n, -1, ackm, busy_mid);
      chk($sformatf("rnd%0d_ack", t), 32'(ackm), 32'(eack));
      chk($sformatf("rnd%0d_nwr", t), 32'(n_wr - n0), 32'(ewr));
      if (ewr) chk($sformatf("rnd%0d_wr", t), {16'd0, last_a, last_d}, {16'd0, ea, ed});
      if (!addressed) chk($sformatf("rnd%0d_sda_idle", t), 32'(dut_low_cnt), 32'd0);
      ridx = 4'($urandom_range(0, 15));
      bus_if.rd_addr = ridx;
      #1;
      chk($sformatf("rnd%0d_rd%0d", t, ridx), 32'(bus_if.rd_data), 32'(ref_read(ridx)));
    end
    for (int r = 0; r < 10; r++) begin
      bus_if.rd_addr = 4'(r);
      #1;
      chk($sformatf("rnd_final_rd%0d", r), 32'(bus_if.rd_data), 32'(ref_read(4'(r))));
    end

    // Reset once byte 2 has been clocked in and the target is driving its ack
    xfer(mk(8'h34, 8'h0D, 8'h77, 8'h00), 3, -1, ackm, busy_mid);
    bus_if.rd_addr = 4'd6;
    #1;
    chk("pre_reset_rd6", 32'(bus_if.rd_data), 32'h177);
    n0 = n_wr;
    i2c_start();
    send_byte(8'h34, -1, busy_mid);
    send_byte(8'h0C, -1, busy_mid);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h5A >> i), 1'b0);
    m_sda_low = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = (sda_bus === 1'b0);
    end
    chk("ack2_drive_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("reset_sda_release", 32'(sda_bus), 32'd1);
    chk("reset_busy", 32'(bus_if.busy), 32'd0);
    m_scl = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("reset_no_write", 32'(n_wr - n0), 32'd0);
    chk("reset_rd6", 32'(bus_if.rd_data), 32'd0);

    n0 = n_wr;
    xfer(mk(8'h34, 8'h0C, 8'h1F, 8'h00), 3, -1, ackm, busy_mid);
    chk("post_reset_ack", 32'(ackm), 32'b0111);
    chk("post_reset_nwr", 32'(n_wr - n0), 32'd1);
    #1;
    chk("post_reset_rd6", 32'(bus_if.rd_data), 32'h01F);
    chk("wr_pulse_width", 32'(wide_pulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_codec_target.md
I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, 7-bit target address matched against the first byte after START.
REQ-002 SHALL have parameter FILT_LEN, default 3, number of consecutive equal samples required to accept a new SCL/SDA level.
REQ-003 SHALL have port clk_50mhz, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port i2c_sclk_i, input, 1 bit, I2C clock from the bus, asynchronous to clk_50mhz.
REQ-006 SHALL have port i2c_sdin_io, inout, 1 bit, open-drain SDA: driven 0 when acknowledging, high-Z otherwise, never driven 1.
REQ-007 SHALL have port wr_valid_o, output, 1 bit, one-cycle pulse for each completed register write.
REQ-008 SHALL have port wr_addr_o, output, 7 bits, register address of the last completed write.
REQ-009 SHALL have port wr_data_o, output, 9 bits, register data of the last completed write.
REQ-010 SHALL have port busy_o, output, 1 bit, high from an address-matched START until the next STOP.
REQ-011 SHALL have port rd_addr_i, input, 4 bits, register-file read index.
REQ-012 SHALL have port rd_data_o, output, 9 bits, combinational register-file read data.

Function
REQ-013 SHALL synchronize SCL and SDA with two flops each, then apply the FILT_LEN filter; all following rules use the filtered levels.
REQ-014 SHALL detect START as filtered SDA 1->0 while SCL=1, and STOP as filtered SDA 0->1 while SCL=1.
REQ-015 SHALL sample SDA on the filtered SCL rising edge, MSB first, and change its own SDA drive only on the filtered SCL falling edge.
REQ-016 SHALL use states IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
REQ-017 START from any state SHALL go to ADDR with the bit counter cleared; repeated START counts as START.
REQ-018 STOP from any state SHALL go to IDLE, release SDA and discard any partial transfer.
REQ-019 After 8 address bits, with byte[7:1]==DEV_ADDR and byte[0]==0, SHALL go to ADDR_ACK; otherwise (mismatch or read) SHALL go to IGNORE without driving SDA.
REQ-020 In each ACK state SHALL drive SDA low from the SCL falling edge after bit 8 until the SCL falling edge after the 9th clock, then release.
REQ-021 State sequence SHALL be ADDR_ACK->BYTE1->ACK1->BYTE2->ACK2->IGNORE; bytes received after ACK2 SHALL be NACKed (SDA not driven).
REQ-022 At the SCL falling edge ending ACK2, SHALL set wr_addr_o=byte1[7:1] and wr_data_o={byte1[0],byte2}, and pulse wr_valid_o for exactly one cycle on the following clk_50mhz cycle.
REQ-023 Register file SHALL hold registers 0..9, 9 bits each, written at the wr_valid_o pulse when wr_addr_o<=9.
REQ-024 A write to address 15 SHALL clear registers 0..9 to 0; writes to addresses 10..14 and 16..127 SHALL pulse wr_valid_o and leave the file unchanged.
REQ-025 rd_data_o SHALL return 0 for rd_addr_i>9.
REQ-026 busy_o SHALL set on entry to ADDR_ACK and clear on STOP or on a START whose address does not match.

Reset
REQ-027 While rst_i=1, SHALL hold state IDLE, SDA high-Z, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, all registers 0, and synchronizer/filter outputs 1.
REQ-028 Reset asserted mid-transaction SHALL release SDA within the same cycle (asynchronous) and produce no write.

Verification
REQ-029 START, 0x34, 0x0C, 0x1F, STOP -> three ACKs; one wr_valid_o pulse with addr 6, data 0x01F; rd_addr_i=6 gives 0x01F.
REQ-030 START, 0x34, 0x0D, 0xFF, STOP -> addr 6, data 0x1FF; then START, 0x34, 0x1E, 0x00, STOP -> addr 15 pulse; registers 0..9 read 0.
REQ-031 START, 0x36, ... STOP (address mismatch) and START, 0x35 (read) -> SDA never driven low; no wr_valid_o; busy_o stays 0.
REQ-032 START, 0x34, 0x0C, STOP -> two ACKs; no wr_valid_o; register 6 unchanged.
REQ-033 START, 0x34, 0x0C, 0x1F, 0xAA, STOP -> one write (addr 6, data 0x01F); 4th byte NACKed.
REQ-034 A 1-cycle SCL glitch during BYTE1 -> ignored by the filter, and the write completes correctly; asserting rst_i during BYTE2 -> SDA released immediately, no write.
